// File: rtl/contador_pkg.sv
// Shared types and step arithmetic for the up/down setpoint counter.
// Next-value math is done in 32 bits so it never overflows.
package contador_pkg;

  typedef enum logic [1:0] {
    OCIOSO,
    ESPERA,
    REPETE
  } estado_t;

  localparam bit MODO_SATURA   = 1'b0;
  localparam bit MODO_CIRCULAR = 1'b1;

  function automatic logic [31:0] proximo_valor(
    input logic [31:0] s,
    input logic        sobe,
    input bit          modo,
    input logic [31:0] passo,
    input logic [31:0] minimo,
    input logic [31:0] maximo
  );
    logic [31:0] r;
    if (sobe) begin
      if (s + passo > maximo)
        r = (modo == MODO_CIRCULAR)
          ? minimo + (s + passo - maximo - 1)
          : maximo;
      else
        r = s + passo;
    end else begin
      if (s < minimo + passo)
        r = (modo == MODO_CIRCULAR)
          ? maximo - (minimo + passo - s - 1)
          : minimo;
      else
        r = s - passo;
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_updown_parametrizado_repetidor_tecla.sv
// Edge detection and hold-to-repeat sequencing for the inc/dec requests.
// Emits single-cycle step strobes; the caller gates them with habilita.
module repetidor_tecla
  import contador_pkg::*;
#(
  parameter int ATRASO_REPETICAO  = 0,
  parameter int PERIODO_REPETICAO = 1,
  parameter int LARGURA_TEMPO     = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic habilita,
  input  logic incrementa,
  input  logic decrementa,
  input  logic carga,
  output logic passo_up,
  output logic passo_dn
);

  localparam bit COM_REPETICAO = ATRASO_REPETICAO > 0;
  localparam logic [LARGURA_TEMPO-1:0] ALVO_ATRASO =
    COM_REPETICAO ? LARGURA_TEMPO'(ATRASO_REPETICAO - 1) : '0;
  localparam logic [LARGURA_TEMPO-1:0] ALVO_PERIODO =
    LARGURA_TEMPO'(PERIODO_REPETICAO - 1);

  estado_t                  estado;
  logic [LARGURA_TEMPO-1:0] timer;
  logic                     prev_up;
  logic                     prev_dn;
  logic                     dir;

  logic req_up, req_dn;
  logic borda_up, borda_dn;
  logic mesmo;

  assign req_up   = incrementa & ~decrementa;
  assign req_dn   = decrementa & ~incrementa;
  assign borda_up = req_up & ~prev_up;
  assign borda_dn = req_dn & ~prev_dn;
  assign mesmo    = dir ? req_up : req_dn;

  always_comb begin
    passo_up = 1'b0;
    passo_dn = 1'b0;
    if (!carga) begin
      unique case (estado)
        OCIOSO: begin
          passo_up = borda_up;
          passo_dn = borda_dn;
        end
        ESPERA: begin
          if (mesmo && timer == ALVO_ATRASO) begin
            passo_up = dir;
            passo_dn = ~dir;
          end
        end
        REPETE: begin
          if (mesmo && timer == ALVO_PERIODO) begin
            passo_up = dir;
            passo_dn = ~dir;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= OCIOSO;
      timer   <= '0;
      prev_up <= 1'b0;
      prev_dn <= 1'b0;
      dir     <= 1'b0;
    end else if (habilita) begin
      prev_up <= req_up;
      prev_dn <= req_dn;
      if (carga) begin
        estado <= OCIOSO;
        timer  <= '0;
      end else begin
        unique case (estado)
          OCIOSO: begin
            timer <= '0;
            if (borda_up || borda_dn) begin
              dir    <= borda_up;
              estado <= COM_REPETICAO ? ESPERA : OCIOSO;
            end
          end
          ESPERA, REPETE: begin
            if (!mesmo) begin
              // Abort: forget history so a new direction edges next cycle
              estado  <= OCIOSO;
              timer   <= '0;
              prev_up <= 1'b0;
              prev_dn <= 1'b0;
            end else if (estado == ESPERA) begin
              if (timer == ALVO_ATRASO) begin
                timer  <= '0;
                estado <= REPETE;
              end else begin
                timer <= timer + 1'b1;
              end
            end else begin
              if (timer == ALVO_PERIODO)
                timer <= '0;
              else
                timer <= timer + 1'b1;
            end
          end
          default: begin
            estado <= OCIOSO;
            timer  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/contador_updown_parametrizado.sv
// Saturating/circular up-down counter for PWM duty and period setpoints.
// Load has priority over steps; flags decode the registered value.
module contador_updown_parametrizado #(
  parameter int LARGURA           = 7,
  parameter int MINIMO            = 0,
  parameter int MAXIMO            = 99,
  parameter int INICIAL           = 0,
  parameter int PASSO             = 1,
  parameter int MODO_CIRCULAR     = 0,
  parameter int ATRASO_REPETICAO  = 0,
  parameter int PERIODO_REPETICAO = 1,
  parameter int LARGURA_TEMPO     = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               habilita,
  input  logic               incrementa,
  input  logic               decrementa,
  input  logic               carga,
  input  logic [LARGURA-1:0] valor_carga,
  output logic [LARGURA-1:0] saida,
  output logic               no_minimo,
  output logic               no_maximo,
  output logic               passo_ocorreu
);

  import contador_pkg::*;

  localparam logic [LARGURA-1:0] MIN_L = LARGURA'(MINIMO);
  localparam logic [LARGURA-1:0] MAX_L = LARGURA'(MAXIMO);
  localparam logic [LARGURA-1:0] INI_L = LARGURA'(INICIAL);
  localparam bit                 CIRC  = MODO_CIRCULAR != 0;

  logic               passo_up;
  logic               passo_dn;
  logic [LARGURA-1:0] valor_up;
  logic [LARGURA-1:0] valor_dn;
  logic [LARGURA-1:0] valor_lim;

  repetidor_tecla #(
    .ATRASO_REPETICAO (ATRASO_REPETICAO),
    .PERIODO_REPETICAO(PERIODO_REPETICAO),
    .LARGURA_TEMPO    (LARGURA_TEMPO)
  ) u_repetidor (
    .clock     (clock),
    .reset     (reset),
    .habilita  (habilita),
    .incrementa(incrementa),
    .decrementa(decrementa),
    .carga     (carga),
    .passo_up  (passo_up),
    .passo_dn  (passo_dn)
  );

  assign valor_up = LARGURA'(proximo_valor(
    32'(saida), 1'b1, CIRC,
    32'(PASSO), 32'(MINIMO), 32'(MAXIMO)));
  assign valor_dn = LARGURA'(proximo_valor(
    32'(saida), 1'b0, CIRC,
    32'(PASSO), 32'(MINIMO), 32'(MAXIMO)));

  always_comb begin
    valor_lim = valor_carga;
    unique case (1'b1)
      (valor_carga < MIN_L): valor_lim = MIN_L;
      (valor_carga > MAX_L): valor_lim = MAX_L;
      default:               valor_lim = valor_carga;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      saida         <= INI_L;
      passo_ocorreu <= 1'b0;
    end else if (habilita) begin
      unique case (1'b1)
        carga: begin
          saida         <= valor_lim;
          passo_ocorreu <= 1'b0;
        end
        passo_up: begin
          saida         <= valor_up;
          passo_ocorreu <= 1'b1;
        end
        passo_dn: begin
          saida         <= valor_dn;
          passo_ocorreu <= 1'b1;
        end
        default: passo_ocorreu <= 1'b0;
      endcase
    end
  end

  assign no_minimo = saida == MIN_L;
  assign no_maximo = saida == MAX_L;

endmodule
